// File: rtl/mmu_ctrl.sv
// Multi-cycle memory controller: CPU req/ready port to banked SRAM, UART and LED/DPY registers.
// SRAM wait states and UART strobe width are fixed by parameters.
module mmu_ctrl #(
  parameter int NUM_BANKS    = 2,
  parameter int BANK_ADDR_W  = 20,
  parameter int BANK_SEL_LSB = 22,
  parameter int WAIT_CYCLES  = 1,
  parameter int UART_PULSE   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic [4:0]             bytemode,
  output logic                   ready,
  output logic [31:0]            rdata,
  inout  wire  [NUM_BANKS*32-1:0] ram_data,
  output logic [BANK_ADDR_W-1:0] ram_addr,
  output logic [3:0]             ram_be_n,
  output logic [NUM_BANKS-1:0]   ram_ce_n,
  output logic [NUM_BANKS-1:0]   ram_oe_n,
  output logic [NUM_BANKS-1:0]   ram_we_n,
  output logic                   uart_rdn,
  output logic                   uart_wrn,
  input  logic                   uart_dataready,
  input  logic                   uart_tsre,
  output logic [15:0]            leds,
  output logic [7:0]             dpys
);
  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_MAX = (WAIT_CYCLES > UART_PULSE - 1) ? WAIT_CYCLES : UART_PULSE - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SRAM_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] UART_LAST = CNT_W'(UART_PULSE - 1);
  localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;
  localparam logic [31:0] LEDS_ADDR      = 32'hBFD0_0400;
  localparam logic [31:0] DPYS_ADDR      = 32'hBFD0_0408;

  typedef enum logic [1:0] {S_IDLE, S_SRAM, S_UART, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [3:0]             mask_q, mask_d;
  logic                   zext_q, zext_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
  logic [BANK_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            dout_q, dout_d;
  logic [NUM_BANKS-1:0]   drive_q, drive_d;
  logic [NUM_BANKS-1:0]   ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [3:0]             be_n_q, be_n_d;
  logic                   uart_rdn_q, uart_rdn_d, uart_wrn_q, uart_wrn_d;
  logic                   ready_q, ready_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [15:0]            leds_q, leds_d;
  logic [7:0]             dpys_q, dpys_d;

  logic [31:0]            bank_bus [NUM_BANKS];
  logic [3:0]             in_mask;
  logic [BANK_W-1:0]      in_bank;
  logic [NUM_BANKS-1:0]   in_oh;
  logic [31:0]            io_rd;

  // Write data stays on the bus into DONE so it outlasts we_n.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign ram_data[gi*32 +: 32] = drive_q[gi] ? dout_q : 32'bz;
    assign bank_bus[gi]          = ram_data[gi*32 +: 32];
  end

  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [3:0] m);
    case (m)
      4'b0001: store_lanes = {24'b0, wd[7:0]};
      4'b0010: store_lanes = {16'b0, wd[7:0], 8'b0};
      4'b0100: store_lanes = {8'b0, wd[7:0], 16'b0};
      4'b1000: store_lanes = {wd[7:0], 24'b0};
      4'b0011: store_lanes = {16'b0, wd[15:0]};
      4'b1100: store_lanes = {wd[15:0], 16'b0};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_lanes(input logic [31:0] w, input logic [3:0] m,
                                             input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    case (m)
      4'b0001: b = w[7:0];
      4'b0010: b = w[15:8];
      4'b0100: b = w[23:16];
      4'b1000: b = w[31:24];
      default: b = 8'h00;
    endcase
    h = m[3] ? w[31:16] : w[15:0];
    if (m == 4'b0001 || m == 4'b0010 || m == 4'b0100 || m == 4'b1000)
      load_lanes = zext ? {24'b0, b} : {{24{b[7]}}, b};
    else if (m == 4'b0011 || m == 4'b1100)
      load_lanes = zext ? {16'b0, h} : {{16{h[15]}}, h};
    else
      load_lanes = w;
  endfunction

  always_comb begin
    in_mask = (bytemode[3:0] == 4'b0000) ? 4'b1111 : bytemode[3:0];
    in_bank = '0;
    if (NUM_BANKS > 1) in_bank = addr[BANK_SEL_LSB +: BANK_W];
    in_oh          = '0;
    in_oh[in_bank] = 1'b1;
    case (addr)
      UART_STAT_ADDR: io_rd = {30'b0, uart_dataready, uart_tsre};
      LEDS_ADDR:      io_rd = {16'b0, leds_q};
      DPYS_ADDR:      io_rd = {24'b0, dpys_q};
      default:        io_rd = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    mask_d     = mask_q;
    zext_d     = zext_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    drive_d    = drive_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    be_n_d     = be_n_q;
    uart_rdn_d = uart_rdn_q;
    uart_wrn_d = uart_wrn_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    leds_d     = leds_q;
    dpys_d     = dpys_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d   = we;
          mask_d = in_mask;
          zext_d = bytemode[4];
          bank_d = in_bank;
          addr_d = addr[BANK_ADDR_W+1:2];
          cnt_d  = '0;
          if (addr[31:16] != 16'hBFD0) begin
            state_d = S_SRAM;
            ce_n_d  = ~in_oh;
            be_n_d  = ~in_mask;
            if (we) begin
              we_n_d  = ~in_oh;
              drive_d = in_oh;
              dout_d  = store_lanes(wdata, in_mask);
            end else begin
              oe_n_d = ~in_oh;
            end
          end else if (addr == UART_DATA_ADDR) begin
            state_d = S_UART;
            if (we) begin
              uart_wrn_d = 1'b0;
              drive_d    = '0;
              drive_d[0] = 1'b1;
              dout_d     = wdata;
            end else begin
              uart_rdn_d = 1'b0;
            end
          end else begin
            // Register and unmapped I/O finish in a single cycle.
            state_d = S_DONE;
            ready_d = 1'b1;
            if (we) begin
              if (addr == LEDS_ADDR) leds_d = wdata[15:0];
              if (addr == DPYS_ADDR) dpys_d = wdata[7:0];
            end else begin
              rdata_d = io_rd;
            end
          end
        end
      end
      S_SRAM: begin
        if (cnt_q == SRAM_LAST) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          ce_n_d  = '1;
          oe_n_d  = '1;
          we_n_d  = '1;
          if (!we_q) rdata_d = load_lanes(bank_bus[bank_q], mask_q, zext_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UART: begin
        if (cnt_q == UART_LAST) begin
          state_d    = S_DONE;
          ready_d    = 1'b1;
          uart_rdn_d = 1'b1;
          uart_wrn_d = 1'b1;
          if (!we_q) rdata_d = {24'b0, bank_bus[0][7:0]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        drive_d = '0;
        be_n_d  = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      mask_q     <= 4'hF;
      zext_q     <= 1'b0;
      bank_q     <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      drive_q    <= '0;
      ce_n_q     <= '1;
      oe_n_q     <= '1;
      we_n_q     <= '1;
      be_n_q     <= 4'hF;
      uart_rdn_q <= 1'b1;
      uart_wrn_q <= 1'b1;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      leds_q     <= '0;
      dpys_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      mask_q     <= mask_d;
      zext_q     <= zext_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      drive_q    <= drive_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      uart_rdn_q <= uart_rdn_d;
      uart_wrn_q <= uart_wrn_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      leds_q     <= leds_d;
      dpys_q     <= dpys_d;
    end
  end

  assign ready    = ready_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_be_n = be_n_q;
  assign ram_ce_n = ce_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign uart_rdn = uart_rdn_q;
  assign uart_wrn = uart_wrn_q;
  assign leds     = leds_q;
  assign dpys     = dpys_q;

endmodule

// File: tb/tb_mmu_ctrl.sv
// Bench for mmu_ctrl: SRAM/UART bus models plus a byte-level reference memory.
// Released buses are pulled up, so an undriven bank reads as all ones.
module tb_mmu_ctrl;
  localparam int NB = 2;
  localparam int WC = 1;
  localparam int UP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     addr = '0;
  logic [31:0]     wdata = '0;
  logic [4:0]      bytemode = '0;
  logic            ready;
  logic [31:0]     rdata;
  wire  [NB*32-1:0] ram_data;
  logic [19:0]     ram_addr;
  logic [3:0]      ram_be_n;
  logic [NB-1:0]   ram_ce_n, ram_oe_n, ram_we_n;
  logic            uart_rdn, uart_wrn;
  logic            uart_dataready = 1'b0;
  logic            uart_tsre = 1'b0;
  logic [15:0]     leds;
  logic [7:0]      dpys;

  mmu_ctrl #(.NUM_BANKS(NB), .BANK_ADDR_W(20), .BANK_SEL_LSB(22),
             .WAIT_CYCLES(WC), .UART_PULSE(UP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .bytemode(bytemode), .ready(ready), .rdata(rdata), .ram_data(ram_data),
    .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tsre(uart_tsre), .leds(leds), .dpys(dpys));

  always #5 clk = ~clk;

  // Environment: asynchronous SRAM per bank and a UART that answers on bank 0.
  logic [31:0] sram [NB][256];
  logic        env_init = 1'b0;
  logic [7:0]  uart_rx = 8'h00;

  function automatic logic [31:0] init_word(input int b, input int i);
    return 32'(b * 256 + i + 1) * 32'h9E37_79B9;
  endfunction

  for (genvar gi = 0; gi < NB*32; gi++) begin : g_pu
    pullup pu (ram_data[gi]);
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_sram
    if (gi == 0) begin : g_b0
      assign ram_data[31:0] = (!ram_ce_n[0] && !ram_oe_n[0]) ? sram[0][ram_addr[7:0]] :
                              (!uart_rdn ? {24'hA5A5A5, uart_rx} : 32'bz);
    end else begin : g_bn
      assign ram_data[gi*32 +: 32] = (!ram_ce_n[gi] && !ram_oe_n[gi]) ?
                                     sram[gi][ram_addr[7:0]] : 32'bz;
    end
  end

  always @(negedge clk) begin
    if (!env_init) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < 256; i++) sram[b][i] <= init_word(b, i);
      env_init <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++)
        if (!ram_ce_n[b] && !ram_we_n[b])
          for (int l = 0; l < 4; l++)
            if (!ram_be_n[l]) sram[b][ram_addr[7:0]][l*8 +: 8] <= ram_data[b*32 + l*8 +: 8];
    end
  end

  // Reference memory: one word per location, updated lane by lane from the access rules.
  logic [31:0] ref_word [NB][256];

  task automatic ref_store(input int b, input int i, input logic [4:0] bm, input logic [31:0] wd);
    logic [3:0] m;
    m = (bm[3:0] == 4'b0000) ? 4'hF : bm[3:0];
    if ($countones(m) == 1) begin
      for (int l = 0; l < 4; l++) if (m[l]) ref_word[b][i][l*8 +: 8] = wd[7:0];
    end else if (m == 4'hC) begin
      ref_word[b][i][31:16] = wd[15:0];
    end else if (m == 4'h3) begin
      ref_word[b][i][15:0] = wd[15:0];
    end else begin
      for (int l = 0; l < 4; l++) if (m[l]) ref_word[b][i][l*8 +: 8] = wd[l*8 +: 8];
    end
  endtask

  function automatic logic [31:0] ref_load(input int b, input int i, input logic [4:0] bm);
    logic [3:0]  m;
    logic [31:0] w;
    int          sv;
    m = (bm[3:0] == 4'b0000) ? 4'hF : bm[3:0];
    w = ref_word[b][i];
    if ($countones(m) == 1) begin
      sv = 0;
      for (int l = 0; l < 4; l++) if (m[l]) sv = bm[4] ? int'(w[l*8 +: 8]) : int'($signed(w[l*8 +: 8]));
      return 32'(sv);
    end else if (m == 4'hC || m == 4'h3) begin
      sv = m[3] ? (bm[4] ? int'(w[31:16]) : int'($signed(w[31:16])))
                : (bm[4] ? int'(w[15:0])  : int'($signed(w[15:0])));
      return 32'(sv);
    end
    return w;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          lat;
  int          ce_lo [NB];
  int          oe_lo [NB];
  int          we_lo [NB];
  int          rdn_lo, wrn_lo;
  logic [3:0]  obs_be;
  logic [19:0] obs_addr;
  logic [7:0]  obs_u0;
  logic [31:0] obs_dd;
  logic        bus0_rel;
  logic [31:0] exp_rd = '0;

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] bm, input int sel);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; bytemode = bm;
    lat = 0; rdn_lo = 0; wrn_lo = 0; bus0_rel = 1'b1;
    obs_be = 4'hF; obs_addr = '0; obs_u0 = '0; obs_dd = '0;
    for (int b = 0; b < NB; b++) begin ce_lo[b] = 0; oe_lo[b] = 0; we_lo[b] = 0; end
    do begin
      @(posedge clk); #1; lat++;
      if (!ready) begin
        for (int b = 0; b < NB; b++) begin
          if (!ram_ce_n[b]) ce_lo[b]++;
          if (!ram_oe_n[b]) oe_lo[b]++;
          if (!ram_we_n[b]) we_lo[b]++;
        end
        if (ram_ce_n != '1) begin obs_be = ram_be_n; obs_addr = ram_addr; end
        if (!uart_rdn) rdn_lo++;
        if (!uart_wrn) begin wrn_lo++; obs_u0 = ram_data[7:0]; end
      end else begin
        obs_dd = ram_data[sel*32 +: 32];
      end
      if (ram_data[31:0] !== 32'hFFFF_FFFF) bus0_rel = 1'b0;
    end while (!ready && lat < 40);
    req = 1'b0;
    check("ready_seen", ready, 1'b1);
    $display("[TB] %s addr=%h wdata=%h bm=%b rdata=%h lat=%0d",
             w ? "WR" : "RD", a, wd, bm, rdata, lat);
    @(posedge clk); #1;
    check("ready_single", ready, 1'b0);
  endtask

  initial begin
    logic        saw;
    logic        w;
    int          b, i;
    logic [4:0]  bm;
    logic [3:0]  masks [9];
    logic [31:0] wd, a;

    for (int bb = 0; bb < NB; bb++)
      for (int ii = 0; ii < 256; ii++) ref_word[bb][ii] = init_word(bb, ii);
    masks[0] = 4'h1; masks[1] = 4'h2; masks[2] = 4'h4; masks[3] = 4'h8; masks[4] = 4'h3;
    masks[5] = 4'hC; masks[6] = 4'hF; masks[7] = 4'h0; masks[8] = 4'h7;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_leds_dpys", {leds, dpys}, 24'h0);
    check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, ram_be_n},
          {(NB*3+6){1'b1}});
    check("rst_bus", ram_data, {(NB*32){1'b1}});
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Full-word write and read-back on bank 0
    access(1'b1, 32'h8000_0010, 32'h1234_5678, 5'b01111, 0);
    ref_store(0, 4, 5'b01111, 32'h1234_5678);
    check("wr_latency", lat, WC + 2);
    check("wr_we_cycles", we_lo[0], WC + 1);
    check("wr_ce_cycles", {ce_lo[0], ce_lo[1]}, {32'(WC + 1), 32'd0});
    check("wr_ram_addr", obs_addr, 20'h00004);
    check("wr_data_held", obs_dd, 32'h1234_5678);
    check("wr_keeps_rdata", rdata, exp_rd);
    access(1'b0, 32'h8000_0010, 32'h0, 5'b01111, 0);
    check("rd_oe_cycles", oe_lo[0], WC + 1);
    check("rd_word", rdata, 32'h1234_5678);
    exp_rd = rdata;

    // Byte lane 2 store, sign- and zero-extended loads
    access(1'b1, 32'h8000_0020, 32'h0000_00AB, 5'b00100, 0);
    ref_store(0, 8, 5'b00100, 32'h0000_00AB);
    check("byte_be_n", obs_be, 4'b1011);
    check("byte_lane_data", obs_dd[23:16], 8'hAB);
    access(1'b0, 32'h8000_0020, 32'h0, 5'b00100, 0);
    check("byte_sext", rdata, 32'hFFFF_FFAB);
    access(1'b0, 32'h8000_0020, 32'h0, 5'b10100, 0);
    check("byte_zext", rdata, 32'h0000_00AB);
    exp_rd = rdata;

    // Bank 1 select leaves bank 0 untouched
    access(1'b1, 32'h8040_0000, 32'hDEAD_BEEF, 5'b01111, 1);
    ref_store(1, 0, 5'b01111, 32'hDEAD_BEEF);
    check("b1_strobes", {ce_lo[1], we_lo[1]}, {32'(WC + 1), 32'(WC + 1)});
    check("b1_bank0_quiet", {ce_lo[0], we_lo[0]}, 64'h0);
    check("b1_bus0_released", bus0_rel, 1'b1);
    check("b1_data", obs_dd, 32'hDEAD_BEEF);

    // UART write, read and status
    access(1'b1, 32'hBFD0_03F8, 32'h0000_0041, 5'b01111, 0);
    check("uart_wr_pulse", wrn_lo, UP);
    check("uart_wr_data", obs_u0, 8'h41);
    check("uart_wr_latency", lat, UP + 1);
    check("uart_no_bank", {ce_lo[0], ce_lo[1]}, 64'h0);
    check("uart_wr_keeps_rdata", rdata, exp_rd);
    uart_rx = 8'h5C;
    access(1'b0, 32'hBFD0_03F8, 32'h0, 5'b01111, 0);
    check("uart_rd_pulse", rdn_lo, UP);
    check("uart_rd_data", rdata, 32'h0000_005C);
    uart_dataready = 1'b1; uart_tsre = 1'b0;
    access(1'b0, 32'hBFD0_03FC, 32'h0, 5'b01111, 0);
    check("uart_status", rdata, 32'h2);
    check("status_latency", lat, 1);

    // LED / display registers and unmapped I/O
    access(1'b1, 32'hBFD0_0400, 32'h0000_BEEF, 5'b01111, 0);
    check("leds_latency", lat, 1);
    check("leds_value", leds, 16'hBEEF);
    access(1'b0, 32'hBFD0_0400, 32'h0, 5'b01111, 0);
    check("leds_readback", rdata, 32'h0000_BEEF);
    access(1'b1, 32'hBFD0_0408, 32'h1234_565A, 5'b01111, 0);
    check("dpys_value", dpys, 8'h5A);
    access(1'b0, 32'hBFD0_0408, 32'h0, 5'b01111, 0);
    check("dpys_readback", rdata, 32'h0000_005A);
    access(1'b0, 32'hBFD0_0010, 32'h0, 5'b01111, 0);
    check("unmapped_read", rdata, 32'h0);
    check("unmapped_latency", lat, 1);
    exp_rd = rdata;

    // Random SRAM traffic against the reference memory
    for (int n = 0; n < 60; n++) begin
      b  = int'($urandom_range(0, NB - 1));
      i  = int'($urandom_range(0, 255));
      w  = 1'($urandom_range(0, 1));
      bm = {1'($urandom_range(0, 1)), masks[$urandom_range(0, 8)]};
      wd = $urandom;
      a  = 32'h8000_0000 | (32'(b) << 22) | (32'(i) << 2) | 32'($urandom_range(0, 3));
      access(w, a, wd, bm, b);
      check("rnd_latency", lat, WC + 2);
      check("rnd_strobe", ce_lo[b], WC + 1);
      if (w) begin
        ref_store(b, i, bm, wd);
        check("rnd_wr_keeps_rdata", rdata, exp_rd);
      end else begin
        exp_rd = ref_load(b, i, bm);
        check("rnd_read", rdata, exp_rd);
      end
    end

    // Reset in the middle of an SRAM write strobe
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8000_0040; wdata = 32'h0BAD_F00D; bytemode = 5'b01111;
    @(posedge clk); #1;
    check("mid_we_low", ram_we_n, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, ram_be_n},
          {(NB*3+6){1'b1}});
    check("mid_rst_bus", ram_data, {(NB*32){1'b1}});
    check("mid_rst_leds", leds, 16'h0);
    req = 1'b0;
    saw = ready;
    repeat (3) begin @(posedge clk); #1; saw = saw | ready; end
    check("mid_rst_no_ready", saw, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    access(1'b1, 32'h8000_0044, 32'hCAFE_0123, 5'b01111, 0);
    ref_store(0, 17, 5'b01111, 32'hCAFE_0123);
    check("post_rst_latency", lat, WC + 2);
    access(1'b0, 32'h8000_0044, 32'h0, 5'b01111, 0);
    check("post_rst_read", rdata, ref_load(0, 17, 5'b01111));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmu_ctrl.md
Name: mmu_ctrl

Overview:
- Multi-cycle successor to the single-cycle combinational memory decoder.
- Sits between the CPU memory stage and board resources: NUM_BANKS SRAM banks, the UART, and the LED/DPY registers.
- A req/ready handshake replaces clock-phase strobing. The block applies programmable SRAM wait states and UART strobe width, per-lane byte/half/word stores, and sign/zero-extended loads.

Parameters:
- NUM_BANKS, 2: SRAM bank count; power of 2, range 1..4.
- BANK_ADDR_W, 20: word-address width per bank.
- BANK_SEL_LSB, 22: lowest addr bit of the bank select field.
- WAIT_CYCLES, 1: extra SRAM strobe cycles beyond the first.
- UART_PULSE, 2: cycles that uart_rdn/uart_wrn are held low; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- bytemode  in  5  [3:0] lane mask, [4] 1 = zero-extend.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid when ready=1, held until the next completion.
- ram_data  inout  NUM_BANKS*32  bank data buses.
- ram_addr  out  BANK_ADDR_W  shared word address = latched addr[BANK_ADDR_W+1:2].
- ram_be_n  out  4  shared active-low byte enables.
- ram_ce_n / ram_oe_n / ram_we_n  out  NUM_BANKS each  per-bank active-low strobes.
- uart_rdn, uart_wrn  out  1  UART strobes.
- uart_dataready, uart_tsre  in  1  UART status inputs.
- leds  out  16  LED register.
- dpys  out  8  display register.

Behaviour:
- Reset (async, immediate):
  - state IDLE; ready=0; rdata=0; leds=0; dpys=0.
  - All ce/oe/we_n=1; uart_rdn/wrn=1; ram_be_n=4'hF; all ram_data tristate.
  - Any in-flight access is abandoned with no ready.
- Acceptance: req=1 in IDLE latches we/addr/wdata/bytemode. Inputs are ignored outside IDLE. The requester holds req until ready; req high on the cycle after ready starts a new access.
- Decode on latched addr:
  - addr[31:16]=BFD0 is the I/O region.
  - Anything else is SRAM. Bank = addr[BANK_SEL_LSB +: log2(NUM_BANKS)]; with NUM_BANKS=1 the bank is always 0.
- FSM states: IDLE, SRAM, UART, DONE.
- SRAM state:
  - Selected bank has ce_n=0, and oe_n=0 (read) or we_n=0 (write). Strobes are held WAIT_CYCLES+1 cycles.
  - Read data is captured on the last strobe cycle.
  - Then DONE: strobes released, ready=1.
  - Latency: req accepted at edge 0, ready high in cycle WAIT_CYCLES+2.
- Write data:
  - Driven on the selected bank bus only, from the first SRAM cycle through DONE, so data outlasts we_n.
  - Every other bank bus stays tristate.
- Lanes:
  - ram_be_n = ~bytemode[3:0]; mask 0000 is treated as 1111.
  - Stores: a single-lane mask places wdata[7:0] in that lane. Mask 1100 puts wdata[15:0] in [31:16]; mask 0011 puts it in [15:0]. Any other mask writes the full word.
  - Loads: a single-lane mask returns that byte; masks 1100/0011 return that half. The result is sign-extended, or zero-extended if bytemode[4]=1. Any other mask returns the full word.
- UART (BFD003F8):
  - Read: uart_rdn=0 for UART_PULSE cycles; rdata={24'b0, bank0 data[7:0]} captured in the last low cycle.
  - Write: bank0 bus driven with wdata, uart_wrn=0 for UART_PULSE cycles.
  - Then DONE. Bank strobes stay inactive throughout.
- Register accesses (IDLE→DONE directly, ready in cycle 1):
  - BFD003FC read: {30'b0, uart_dataready, uart_tsre}.
  - BFD00400: write leds=wdata[15:0]; read returns {16'b0, leds}.
  - BFD00408: write dpys=wdata[7:0]; read returns {24'b0, dpys}.
  - Other BFD0xxxx addresses: reads return 0, writes are ignored, 1-cycle completion.
- Writes leave rdata unchanged. ready is never high for two consecutive cycles.

Test Plan:
- Reset, then write 0x12345678 to 0x80000010 with mask 1111, WAIT_CYCLES=1 → bank0 we_n low for 2 cycles, ram_addr=0x00004, ready in cycle 3. A read of the same address returns 0x12345678.
- Byte store 0xAB to lane 2 (mask 0100), then a sign-extended read with mask 0100 → be_n=1011, rdata=0xFFFFFFAB. Zero-extended read (bytemode 10100) → 0x000000AB.
- Access to 0x80400000 (bit 22 set) → only bank1 ce_n/we_n assert, and the bank0 bus stays Z.
- UART write 0x41 to BFD003F8, UART_PULSE=2 → uart_wrn low exactly 2 cycles with bank0 data[7:0]=0x41, then ready. A status read with dataready=1, tsre=0 → rdata=0x2.
- Write 0xBEEF to BFD00400 → leds=0xBEEF after 1 cycle, and a readback returns 0x0000BEEF.
- Assert rst_n=0 mid-SRAM strobe → all strobes high and buses Z immediately, no ready. A new req after release completes normally.
